// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered integer ALU.
//   alu_op_e     - 3-bit operation select (OP_ADD .. OP_SHR)
//   ALU_WIDTH    - default operand/result width
//   ALU_SHAMT_W  - default shift-amount width, log2 of ALU_WIDTH
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = $clog2(ALU_WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational logical shifter, zero fill in both directions.
// Optional macro ALU_FLAGS_EN adds the shifted-out bit.
// Ports:
//   a       in   WIDTH    value to shift
//   shamt   in   SHAMT_W  shift amount
//   dir     in   1        0 = left, 1 = right
//   shifted out  WIDTH    shifted value
//   shout   out  1        last bit shifted out, 0 when shamt == 0 (ALU_FLAGS_EN only)
module alu_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    output logic [WIDTH-1:0]   shifted
`ifdef ALU_FLAGS_EN
    ,
    output logic               shout
`endif
);

`ifdef ALU_FLAGS_EN
    // One guard bit on the far side of each shift catches the last bit that
    // leaves the word; with a zero amount the guard bit stays 0.
    logic [WIDTH:0] l_ext;
    logic [WIDTH:0] r_ext;

    assign l_ext   = {1'b0, a} << shamt;
    assign r_ext   = {a, 1'b0} >> shamt;
    assign shifted = dir ? r_ext[WIDTH:1] : l_ext[WIDTH-1:0];
    assign shout   = dir ? r_ext[0] : l_ext[WIDTH];
`else
    assign shifted = dir ? (a >> shamt) : (a << shamt);
`endif

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU, one operation per enabled clock, latency 1.
// Optional macro ALU_FLAGS_EN adds registered zero/carry/overflow flags.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   result   out  WIDTH  registered operation result
//   a        in   WIDTH  operand A
//   b        in   WIDTH  operand B, low SHAMT_W bits are the shift amount
//   opcode   in   3      operation select (alu_op_e)
//   en       in   1      capture enable
//   valid    out  1      one-cycle pulse after each enabled capture
//   zero     out  1      result is all-zero (ALU_FLAGS_EN only)
//   carry    out  1      carry / not-borrow / shifted-out bit (ALU_FLAGS_EN only)
//   overflow out  1      signed overflow of ADD/SUB (ALU_FLAGS_EN only)
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] result,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    input  logic             en,
    output logic             valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             carry,
    output logic             overflow
`endif
);

    alu_op_e          op;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] nxt_result;

    assign op = alu_op_e'(opcode);

`ifdef ALU_FLAGS_EN
    logic             shout;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             nxt_carry;
    logic             nxt_overflow;
`endif

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .a       (a),
        .shamt   (b[SHAMT_W-1:0]),
        .dir     (op == OP_SHR),
        .shifted (shifted)
`ifdef ALU_FLAGS_EN
        ,
        .shout   (shout)
`endif
    );

`ifdef ALU_FLAGS_EN
    // Top bit of the widened difference is the borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};
`endif

    always_comb begin
        nxt_result = '0;
        case (op)
`ifdef ALU_FLAGS_EN
            OP_ADD:  nxt_result = sum_ext[WIDTH-1:0];
            OP_SUB:  nxt_result = diff_ext[WIDTH-1:0];
`else
            OP_ADD:  nxt_result = a + b;
            OP_SUB:  nxt_result = a - b;
`endif
            OP_AND:  nxt_result = a & b;
            OP_OR:   nxt_result = a | b;
            OP_XOR:  nxt_result = a ^ b;
            OP_NOT:  nxt_result = ~a;
            OP_SHL:  nxt_result = shifted;
            OP_SHR:  nxt_result = shifted;
            default: nxt_result = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        nxt_carry    = 1'b0;
        nxt_overflow = 1'b0;
        case (op)
            OP_ADD: begin
                nxt_carry    = sum_ext[WIDTH];
                // Same-signed operands producing a differently signed sum.
                nxt_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                               (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_carry    = ~diff_ext[WIDTH];
                // Opposite-signed operands with the result sign flipping from a.
                nxt_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                               (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL, OP_SHR: nxt_carry = shout;
            default: begin
                nxt_carry    = 1'b0;
                nxt_overflow = 1'b0;
            end
        endcase
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            valid  <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
`endif
        end else begin
            valid <= en;
            if (en) begin
                result <= nxt_result;
`ifdef ALU_FLAGS_EN
                zero     <= (nxt_result == '0);
                carry    <= nxt_carry;
                overflow <= nxt_overflow;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed vectors followed by random
// operations with occasional asynchronous reset pulses, all checked against
// an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] result;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  opcode;
    logic        en;
    logic        valid;
`ifdef ALU_FLAGS_EN
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_ovf;
`endif

    int          n_chk;
    int          n_pass;
    logic [31:0] exp_res;
    logic        exp_val;

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .en       (en),
        .valid    (valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero     (zero),
        .carry    (carry),
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        int sh = int'(y % 32);
        case (op)
            3'd0: return 32'((ux + uy) % (64'd1 << 32));
            3'd1: return 32'((ux + (64'd1 << 32) - uy) % (64'd1 << 32));
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return 32'hFFFF_FFFF - x;
            3'd6: return 32'((ux * (64'd1 << sh)) % (64'd1 << 32));
            default: return 32'(ux / (64'd1 << sh));
        endcase
    endfunction

`ifdef ALU_FLAGS_EN
    task automatic ref_flags(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s;
        longint unsigned ux = x;
        longint unsigned uy = y;
        int sh = int'(y % 32);
        exp_zero  = (ref_res(op, x, y) == 32'd0);
        exp_carry = 1'b0;
        exp_ovf   = 1'b0;
        case (op)
            3'd0: begin
                exp_carry = (ux + uy) >= (64'd1 << 32);
                s = sx + sy;
                exp_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd1: begin
                exp_carry = (ux >= uy);
                s = sx - sy;
                exp_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd6: if (sh != 0) exp_carry = ((ux >> (32 - sh)) & 64'd1) != 0;
            3'd7: if (sh != 0) exp_carry = ((ux >> (sh - 1)) & 64'd1) != 0;
            default: ;
        endcase
    endtask
`endif

    task automatic check_outputs(input string tag);
        chk({tag, ".result"}, result, exp_res);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_val});
`ifdef ALU_FLAGS_EN
        chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
        chk({tag, ".carry"}, {31'd0, carry}, {31'd0, exp_carry});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
`endif
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare.
    task automatic step(input string tag, input logic e, input logic [2:0] op,
                        input logic [31:0] x, input logic [31:0] y);
        en = e; opcode = op; a = x; b = y;
        @(posedge clk);
        #1;
        if (e) begin
            exp_res = ref_res(op, x, y);
`ifdef ALU_FLAGS_EN
            ref_flags(op, x, y);
`endif
        end
        exp_val = e;
        check_outputs(tag);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        exp_res = '0;
        exp_val = 1'b0;
`ifdef ALU_FLAGS_EN
        exp_zero = 1'b0; exp_carry = 1'b0; exp_ovf = 1'b0;
`endif
        check_outputs(tag);
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b0; en = 1'b0; opcode = 3'd0; a = '0; b = '0;
        exp_res = '0; exp_val = 1'b0;
`ifdef ALU_FLAGS_EN
        exp_zero = 1'b0; exp_carry = 1'b0; exp_ovf = 1'b0;
`endif
        #1 rst = 1'b1;
        #1 check_outputs("reset_async");
        repeat (2) @(posedge clk);
        #1 check_outputs("reset_held");
        rst = 1'b0;
        step("idle_after_reset", 1'b0, 3'd0, 32'd4, 32'd2);

        step("add", 1'b1, 3'd0, 32'd4, 32'd2);
        step("sub", 1'b1, 3'd1, 32'd4, 32'd2);
        step("add_wrap", 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1);
        step("sub_wrap", 1'b1, 3'd1, 32'd0, 32'd1);
        step("add_sovf", 1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1);
        step("sub_sovf", 1'b1, 3'd1, 32'h8000_0000, 32'd1);
        step("and", 1'b1, 3'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step("or", 1'b1, 3'd3, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step("xor", 1'b1, 3'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step("not", 1'b1, 3'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        step("shl1", 1'b1, 3'd6, 32'h8000_0001, 32'h0000_0021);
        step("shr1", 1'b1, 3'd7, 32'h8000_0001, 32'h0000_0021);
        step("shl0", 1'b1, 3'd6, 32'h8000_0001, 32'h0000_0000);
        step("shr0", 1'b1, 3'd7, 32'h8000_0001, 32'h0000_0000);
        step("shl31", 1'b1, 3'd6, 32'h0000_0003, 32'hFFFF_FFFF);
        step("shr31", 1'b1, 3'd7, 32'hC000_0000, 32'h0000_001F);

        step("add_6", 1'b1, 3'd0, 32'd4, 32'd2);
        chk("literal_6", result, 32'd6);
        step("hold1", 1'b0, 3'd3, 32'd99, 32'd7);
        step("hold2", 1'b0, 3'd5, 32'h1234_5678, 32'd1);
        async_reset("reset_midstream");
        step("after_pulse", 1'b0, 3'd0, 32'd1, 32'd1);
        step("resume", 1'b1, 3'd1, 32'd10, 32'd3);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 31) == 0) async_reset("rand_reset");
            else step("rand", ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU that computes one of eight operations on operands a and b, selected by a 3-bit opcode.
- A new result is captured only while en is high; while en is low the previous result is held.
- Used as the arithmetic/logic execution stage of the datapath, between operand selection and writeback.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).
- SHAMT_W, 5, shift-amount width; must equal $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- result  output  WIDTH  registered operation result
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts, b[SHAMT_W-1:0] is the shift amount
- opcode  input  3  operation select
- en  input  1  capture enable
- valid  output  1  high for exactly one cycle after each enabled capture

Behaviour:
- Reset: rst high clears result to 0 and valid to 0 immediately, regardless of clk. Reset takes priority over en at all times, including mid-stream.
- Latency is one cycle. On a rising clk edge with en=1, result <= f(opcode, a, b) and valid <= 1.
- On a rising clk edge with en=0, result holds its value and valid <= 0.
- Opcode map:
  - 000 ADD: a+b, modulo 2^WIDTH
  - 001 SUB: a-b, modulo 2^WIDTH
  - 010 AND: a&b
  - 011 OR: a|b
  - 100 XOR: a^b
  - 101 NOT: ~a (b ignored)
  - 110 SHL: a << b[SHAMT_W-1:0], logical
  - 111 SHR: a >> b[SHAMT_W-1:0], logical, zero fill
- All operands are treated as unsigned. b bits above SHAMT_W are ignored for shifts.
- The combinational next-value is a pure function of the current a, b and opcode; there is no internal state other than the output registers.
- X/Z on opcode is not handled; the bench must drive legal values whenever en=1.
- Back-to-back enabled cycles each produce a new result, giving a throughput of one operation per cycle.

Optional Feature:
- Macro ALU_FLAGS_EN.
- When defined, add registered outputs zero (1), carry (1) and overflow (1), updated under the same en/reset rules as result and reset to 0.
  - zero = next result is all-zero, for every opcode.
  - carry = carry-out for ADD; NOT borrow (a>=b) for SUB; last bit shifted out for SHL/SHR with a nonzero amount; 0 otherwise.
  - overflow = two's-complement signed overflow for ADD/SUB; 0 otherwise.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - the opcode enum (OP_ADD..OP_SHR, 3-bit)
  - the default WIDTH
  - the SHAMT_W localparam
- One sub-module, alu_shifter: combinational barrel shifter with inputs a, shamt and dir, output shifted value, and (under ALU_FLAGS_EN) the shifted-out bit.
- Adder, subtractor and logic operations remain inline in alu.

Test Plan:
- Reset: assert rst with en=0 and opcode=000 -> result=0 and valid=0 immediately; both stay 0 until the first enabled edge after rst deasserts.
- ADD then SUB: a=4, b=2, en=1, opcode=000 -> result=6 one cycle later; switch to opcode=001 -> result=2 on the next cycle, with valid high each cycle.
- Wrap-around: a=32'hFFFF_FFFF, b=1, ADD -> result=0 (carry=1, zero=1 with flags). a=0, b=1, SUB -> result=32'hFFFF_FFFF (carry=0).
- Logic and NOT: a=32'hF0F0_00FF, b=32'h0FF0_0F0F -> AND=32'h00F0_000F, OR=32'hFFF0_0FFF, XOR=32'hFF00_0FF0, NOT=32'h0F0F_FF00.
- Shifts: a=32'h8000_0001, b=32'h0000_0021 (amount 1) -> SHL=32'h0000_0002, SHR=32'h4000_0000. b=0 -> result=a.
- Hold and async reset: compute 6, then drop en and change a/b/opcode -> result stays 6 and valid=0. Pulse rst between clock edges -> result=0 without waiting for a clk edge.
